// File: rtl/axil_rd_arbiter_if.sv
// AXI-Lite read-channel bundle: AR and R signals with arbiter-side modports.
interface axil_interface_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    // Arbiter acting as the read target of an upstream requester.
    modport rd_slv (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );

    // Arbiter acting as the read initiator toward shared memory.
    modport rd_mst (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_rd_arbiter.sv
// Two-requester AXI-Lite read arbiter (fetch vs. data) onto one memory port,
// one read outstanding, data-priority with fetch starvation guard and
// fetch-flush discard of the pending beat.
module axil_rd_arbiter #(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    axil_interface_if.rd_slv if_rd,
    axil_interface_if.rd_slv dm_rd,
    axil_interface_if.rd_mst mem_rd,
    input  logic             flush_if,
    output logic             busy,
    output logic             owner
);

    localparam int unsigned CNT_W      = 4;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        AR_SEND = 2'd1,
        R_WAIT  = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  starve_cnt;
    logic              discard_q;
    logic [ADDR_W-1:0] addr_q;

    logic gnt_i;
    logic gnt_d;
    logic starve_hit;
    logic in_rwait;
    logic r_done;

    assign starve_hit = (starve_cnt == STARVE_MAX);
    assign in_rwait   = (state == R_WAIT);
    assign r_done     = in_rwait && mem_rd.rvalid && mem_rd.rready;

    // Grant decision in IDLE; data wins unless fetch is starved or data is absent.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (rst_n && (state == IDLE)) begin
            if (dm_rd.arvalid && !(starve_hit && if_rd.arvalid && !flush_if)) begin
                gnt_d = 1'b1;
            end else if (if_rd.arvalid && !flush_if) begin
                gnt_i = 1'b1;
            end
        end
    end

    // Upstream AR ready goes only to the granted requester.
    assign if_rd.arready = gnt_i;
    assign dm_rd.arready = gnt_d;

    // Downstream AR channel presents the latched address while in AR_SEND.
    assign mem_rd.arvalid = (state == AR_SEND);
    assign mem_rd.araddr  = addr_q;

    // R channel steering to the owner; a discarded fetch beat is swallowed here.
    assign if_rd.rvalid = in_rwait && !owner && !discard_q && mem_rd.rvalid;
    assign dm_rd.rvalid = in_rwait && owner && mem_rd.rvalid;
    assign if_rd.rdata  = (in_rwait && !owner) ? mem_rd.rdata : DATA_W'(0);
    assign dm_rd.rdata  = (in_rwait && owner)  ? mem_rd.rdata : DATA_W'(0);
    assign if_rd.rresp  = (in_rwait && !owner) ? mem_rd.rresp : 2'b00;
    assign dm_rd.rresp  = (in_rwait && owner)  ? mem_rd.rresp : 2'b00;
    assign mem_rd.rready = in_rwait &&
                           (discard_q || (owner ? dm_rd.rready : if_rd.rready));

    assign busy = (state != IDLE);

    // Transaction FSM with address/owner capture, starvation counter and discard flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            discard_q  <= 1'b0;
            owner      <= 1'b0;
            addr_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_d) begin
                        addr_q <= dm_rd.araddr;
                        owner  <= 1'b1;
                        state  <= AR_SEND;
                        if (if_rd.arvalid && !starve_hit) begin
                            starve_cnt <= starve_cnt + CNT_W'(1);
                        end
                    end else if (gnt_i) begin
                        addr_q     <= if_rd.araddr;
                        owner      <= 1'b0;
                        starve_cnt <= '0;
                        state      <= AR_SEND;
                    end
                end
                AR_SEND: begin
                    if (mem_rd.arready) begin
                        state <= R_WAIT;
                    end
                    if (flush_if && !owner) begin
                        discard_q <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_done) begin
                        state     <= IDLE;
                        discard_q <= 1'b0;
                    end else if (flush_if && !owner) begin
                        discard_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
